// File: rtl/video_timing_pkg.sv
// Shared constants for the raster timing generator.
//  - 720p60 default geometry (1280x720, 1650x750 totals)
//  - Bit positions inside the packed {display_enable, vsync, hsync} word
//  - The eight colour-bar values and a helper that maps a bar index to a colour
// Optional feature macro used elsewhere in this slice: VTG_PATTERN_EN.
package video_timing_pkg;

  localparam int H_ACTIVE_720P = 1280;
  localparam int H_FP_720P     = 110;
  localparam int H_SYNC_720P   = 40;
  localparam int H_BP_720P     = 220;
  localparam int V_ACTIVE_720P = 720;
  localparam int V_FP_720P     = 5;
  localparam int V_SYNC_720P   = 5;
  localparam int V_BP_720P     = 20;

  localparam int HVE_DE = 2;
  localparam int HVE_VS = 1;
  localparam int HVE_HS = 0;

  localparam logic [23:0] COLOR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COLOR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COLOR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COLOR_GREEN   = 24'h00FF00;
  localparam logic [23:0] COLOR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COLOR_RED     = 24'hFF0000;
  localparam logic [23:0] COLOR_BLUE    = 24'h0000FF;
  localparam logic [23:0] COLOR_BLACK   = 24'h000000;

  // Index 8 and above stands for the remainder pixels past the last bar.
  function automatic logic [23:0] bar_color(input logic [3:0] idx);
    logic [23:0] c;
    case (idx)
      4'd0:    c = COLOR_WHITE;
      4'd1:    c = COLOR_YELLOW;
      4'd2:    c = COLOR_CYAN;
      4'd3:    c = COLOR_GREEN;
      4'd4:    c = COLOR_MAGENTA;
      4'd5:    c = COLOR_RED;
      4'd6:    c = COLOR_BLUE;
      4'd7:    c = COLOR_BLACK;
      default: c = COLOR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Bundle between the timing generator and its consumers (hdmi block, pixel source).
//  i_enable       : advance counters (driven by the consumer side)
//  o_hve          : {display_enable, vsync, hsync}
//  o_x, o_y       : raw horizontal / vertical counter of the current output pixel
//  o_line_start   : pulse at o_x == 0
//  o_frame_start  : pulse at o_x == 0 and o_y == 0
//  o_rgb          : colour-bar pattern, only when VTG_PATTERN_EN is defined
// Modports: master = generator side, slave = consumer side.
interface video_timing_gen_if #(
  parameter int CW = 12
);
  logic          i_enable;
  logic [2:0]    o_hve;
  logic [CW-1:0] o_x;
  logic [CW-1:0] o_y;
  logic          o_line_start;
  logic          o_frame_start;
`ifdef VTG_PATTERN_EN
  logic [23:0]   o_rgb;

  modport master (input i_enable, output o_hve, output o_x, output o_y,
                  output o_line_start, output o_frame_start, output o_rgb);
  modport slave  (output i_enable, input o_hve, input o_x, input o_y,
                  input o_line_start, input o_frame_start, input o_rgb);
`else
  modport master (input i_enable, output o_hve, output o_x, output o_y,
                  output o_line_start, output o_frame_start);
  modport slave  (output i_enable, input o_hve, input o_x, input o_y,
                  input o_line_start, input o_frame_start);
`endif
endinterface

// File: rtl/vtg_axis_counter.sv
// One raster axis: a free-running counter over active, front porch, sync and
// back porch regions, with combinational decode of the current count.
//  clk, reset : clock, asynchronous active-high reset
//  step       : advance by one (wraps from TOTAL-1 to 0)
//  count      : current counter value
//  active     : count is inside the active region
//  sync       : sync region decode, already at polarity POL (1 = active-high)
//  wrap       : count is at TOTAL-1, so the next step wraps
module vtg_axis_counter #(
  parameter int ACTIVE = 1280,
  parameter int FP     = 110,
  parameter int SYNC   = 40,
  parameter int BP     = 220,
  parameter int POL    = 1,
  parameter int CW     = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step,
  output logic [CW-1:0] count,
  output logic          active,
  output logic          sync,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST     = CW'(ACTIVE + FP + SYNC + BP - 1);
  localparam logic [CW-1:0] ACT_END  = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_BEG = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_END = CW'(ACTIVE + FP + SYNC);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] count_d, count_q;
  logic          sync_raw;

  // Next counter value: hold, increment or wrap.
  always_comb begin
    count_d = count_q;
    if (step) begin
      if (count_q == LAST) begin
        count_d = '0;
      end else begin
        count_d = count_q + ONE;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Region decode of the present count.
  always_comb begin
    count    = count_q;
    active   = (count_q < ACT_END);
    sync_raw = (count_q >= SYNC_BEG) && (count_q < SYNC_END);
    sync     = (POL != 0) ? sync_raw : ~sync_raw;
    wrap     = (count_q == LAST);
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator for the HDMI transmitter (pixel clock domain).
// Two axis counters give (hc, vc); every output is registered from the
// current (hc, vc), one clock behind the counter state. i_enable=0 freezes
// counters and every output register, so pulses stretch during a freeze.
//  i_hdmi_clk : pixel clock
//  i_reset    : asynchronous, active-high reset
//  vtg        : video_timing_gen_if.master (i_enable in; o_hve, o_x, o_y,
//               o_line_start, o_frame_start and optional o_rgb out)
// Macro VTG_PATTERN_EN adds an 8-bar colour pattern on o_rgb.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_720P,
  parameter int H_FP       = H_FP_720P,
  parameter int H_SYNC     = H_SYNC_720P,
  parameter int H_BP       = H_BP_720P,
  parameter int V_ACTIVE   = V_ACTIVE_720P,
  parameter int V_FP       = V_FP_720P,
  parameter int V_SYNC     = V_SYNC_720P,
  parameter int V_BP       = V_BP_720P,
  parameter int H_SYNC_POL = 1,
  parameter int V_SYNC_POL = 1,
  parameter int CW         = 12
) (
  input  logic               i_hdmi_clk,
  input  logic               i_reset,
  video_timing_gen_if.master vtg
);

  // Idle sync level is the inverse of the asserted level.
  localparam logic       HS_IDLE = (H_SYNC_POL != 0) ? 1'b0 : 1'b1;
  localparam logic       VS_IDLE = (V_SYNC_POL != 0) ? 1'b0 : 1'b1;
  localparam logic [2:0] HVE_RST = {1'b0, VS_IDLE, HS_IDLE};

  logic [CW-1:0] h_count, v_count;
  logic          h_active, h_sync, h_wrap;
  logic          v_active, v_sync, v_wrap_unused;
  logic          v_step;

  logic [2:0]    hve_d, hve_q;
  logic [CW-1:0] x_d, x_q, y_d, y_q;
  logic          line_start_d, line_start_q;
  logic          frame_start_d, frame_start_q;

  assign v_step = vtg.i_enable && h_wrap;

  vtg_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
    .POL(H_SYNC_POL), .CW(CW)
  ) u_h (
    .clk(i_hdmi_clk), .reset(i_reset), .step(vtg.i_enable),
    .count(h_count), .active(h_active), .sync(h_sync), .wrap(h_wrap)
  );

  vtg_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
    .POL(V_SYNC_POL), .CW(CW)
  ) u_v (
    .clk(i_hdmi_clk), .reset(i_reset), .step(v_step),
    .count(v_count), .active(v_active), .sync(v_sync), .wrap(v_wrap_unused)
  );

  // Output decode of the current (hc, vc), held while disabled.
  always_comb begin
    hve_d         = hve_q;
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    if (vtg.i_enable) begin
      hve_d[HVE_DE] = h_active && v_active;
      hve_d[HVE_VS] = v_sync;
      hve_d[HVE_HS] = h_sync;
      x_d           = h_count;
      y_d           = v_count;
      line_start_d  = (h_count == '0);
      frame_start_d = (h_count == '0) && (v_count == '0);
    end else begin
      hve_d         = hve_q;
      x_d           = x_q;
      y_d           = y_q;
      line_start_d  = line_start_q;
      frame_start_d = frame_start_q;
    end
  end

  // Output registers.
  always_ff @(posedge i_hdmi_clk or posedge i_reset) begin
    if (i_reset) begin
      hve_q         <= HVE_RST;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hve_q         <= hve_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vtg.o_hve         = hve_q;
  assign vtg.o_x           = x_q;
  assign vtg.o_y           = y_q;
  assign vtg.o_line_start  = line_start_q;
  assign vtg.o_frame_start = frame_start_q;

`ifdef VTG_PATTERN_EN
  // Bar index tracks hc without a divider: bar_pix counts within a bar,
  // bar_idx saturates at 8 which maps to black for the remainder pixels.
  localparam int            BAR_W    = H_ACTIVE / 8;
  localparam logic [CW-1:0] BAR_LAST = CW'(BAR_W - 1);
  localparam logic [CW-1:0] BAR_ONE  = CW'(1);

  logic [CW-1:0] bar_pix_d, bar_pix_q;
  logic [3:0]    bar_idx_d, bar_idx_q;
  logic [23:0]   rgb_d, rgb_q;

  // Bar tracking next state and pattern decode.
  always_comb begin
    bar_pix_d = bar_pix_q;
    bar_idx_d = bar_idx_q;
    rgb_d     = rgb_q;
    if (vtg.i_enable) begin
      if (h_wrap) begin
        bar_pix_d = '0;
        bar_idx_d = 4'd0;
      end else if (bar_pix_q == BAR_LAST) begin
        bar_pix_d = '0;
        if (bar_idx_q != 4'd8) begin
          bar_idx_d = bar_idx_q + 4'd1;
        end else begin
          bar_idx_d = bar_idx_q;
        end
      end else begin
        bar_pix_d = bar_pix_q + BAR_ONE;
        bar_idx_d = bar_idx_q;
      end
      rgb_d = (h_active && v_active) ? bar_color(bar_idx_q) : 24'h000000;
    end else begin
      bar_pix_d = bar_pix_q;
      bar_idx_d = bar_idx_q;
      rgb_d     = rgb_q;
    end
  end

  // Bar state and the pattern output register.
  always_ff @(posedge i_hdmi_clk or posedge i_reset) begin
    if (i_reset) begin
      bar_pix_q <= '0;
      bar_idx_q <= 4'd0;
      rgb_q     <= 24'h000000;
    end else begin
      bar_pix_q <= bar_pix_d;
      bar_idx_q <= bar_idx_d;
      rgb_q     <= rgb_d;
    end
  end

  assign vtg.o_rgb = rgb_q;
`endif

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Generates raster timing for the HDMI transmitter: hsync, vsync, display enable and pixel coordinates, all from free-running horizontal and vertical counters.
- Drives the `hve` and `rgb` inputs of the `hdmi` block directly, in the pixel clock domain.
- Pixel sources upstream use `o_x`/`o_y` to produce `rgb` aligned with `o_hve`.

Parameters:
- H_ACTIVE, 1280: visible pixels per line
- H_FP, 110: horizontal front porch, in pixels
- H_SYNC, 40: hsync width, in pixels
- H_BP, 220: horizontal back porch, in pixels
- V_ACTIVE, 720: visible lines per frame
- V_FP, 5: vertical front porch, in lines
- V_SYNC, 5: vsync width, in lines
- V_BP, 20: vertical back porch, in lines
- H_SYNC_POL, 1: 1 = hsync active-high, 0 = active-low
- V_SYNC_POL, 1: 1 = vsync active-high, 0 = active-low
- CW, 12: coordinate counter width; must satisfy 2^CW >= H_TOTAL and 2^CW >= V_TOTAL

Ports:
- i_hdmi_clk  in  1  pixel clock
- i_reset  in  1  asynchronous, active-high reset
- i_enable  in  1  1 = advance counters; 0 = freeze all state and outputs
- o_hve  out  3  {display_enable, vsync, hsync}, same packing as the hdmi block's `hve` input
- o_x  out  CW  horizontal counter value of the current output pixel
- o_y  out  CW  vertical counter value of the current output pixel
- o_line_start  out  1  one-cycle pulse when o_x == 0
- o_frame_start  out  1  one-cycle pulse when o_x == 0 and o_y == 0
- o_rgb  out  24  {R,G,B} test pattern; present only with VTG_PATTERN_EN

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Line order: active, front porch, sync, back porch, for both H and V.
- Counters hc and vc both reset to 0.
- When i_enable=1, each clock:
  - hc wraps from H_TOTAL-1 to 0; otherwise it increments.
  - vc increments only on an hc wrap, and wraps from V_TOTAL-1 to 0.
- All outputs are registered from the current (hc, vc); latency is 1 clock from counter state to outputs.
- Output decode:
  - display_enable = (hc < H_ACTIVE) && (vc < V_ACTIVE)
  - hsync is asserted for H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC, XOR'd to match H_SYNC_POL
  - vsync is asserted for V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC, XOR'd to match V_SYNC_POL; it is a function of vc only, so it changes on line boundaries
- o_x and o_y always carry raw hc and vc, including during blanking.
- Reset values:
  - o_hve = {1'b0, ~V_SYNC_POL, ~H_SYNC_POL}
  - o_x = o_y = 0
  - pulse outputs = 0
  - o_rgb = 0
- First enabled edge after reset release: outputs show pixel (0,0) with display_enable=1, o_line_start=1 and o_frame_start=1; counters move to hc=1.
- i_enable=0: counters and every output register hold their value, so pulses stretch for the whole freeze. The bench checks this as specified behaviour.
- Reset asserted mid-line or mid-frame: immediate asynchronous return to the reset values; after release the sequence restarts at (0,0).
- Frame-end corner: at hc = H_TOTAL-1 and vc = V_TOTAL-1, both counters wrap to 0 on the same edge.

Optional Feature:
- Macro: VTG_PATTERN_EN.
- With the macro defined:
  - o_rgb carries 8 vertical colour bars, computed from the same counter state and registered alongside o_hve so they stay aligned.
  - Bar width BAR_W = H_ACTIVE/8 (integer division); bar index comes from a bar counter that resets at hc=0 and advances every BAR_W pixels. No runtime divider.
  - Bar order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - Any remainder pixels past bar 7 are black.
  - o_rgb = 0 whenever display_enable = 0.
- Without the macro: the o_rgb port and the bar logic are absent.

Decomposition:
- Package video_timing_pkg:
  - 720p60 default constants
  - HVE_DE=2, HVE_VS=1, HVE_HS=0 bit indices
  - the 8 bar colour constants
- Sub-module vtg_axis_counter:
  - parameters ACTIVE, FP, SYNC, BP, POL, CW
  - inputs: clk, reset, step
  - outputs: count, active, sync, wrap
  - instantiated once for H (step = i_enable) and once for V (step = i_enable && h_wrap)

Test Plan:
- Reset release, i_enable=1 -> first edge gives o_hve=3'b100, o_x=0, o_y=0, o_frame_start=1; display_enable stays 1 for 1280 cycles, then 0.
- Default parameters, one full line -> hsync=1 for exactly 40 cycles starting at o_x=1390; o_line_start period = 1650 cycles.
- Full frame -> o_frame_start period = 1237500 cycles; vsync high on lines 725..729; 720 lines carry display_enable.
- H_SYNC_POL=0, V_SYNC_POL=0 -> during reset o_hve=3'b011; sync pulses go low at the same positions as the default case.
- i_enable=0 for 10 cycles at o_x=500 -> all outputs frozen; the next enabled edge gives o_x=501. Reset pulse at o_x=900, o_y=300 -> outputs return to reset values immediately; restart at (0,0).
- VTG_PATTERN_EN defined -> o_rgb=FFFFFF at x=0, FFFF00 at x=160, 000000 at x=1120; o_rgb=0 at x=1300.
